i2c_master_address_transmitter: RTL and testbench
=================================================

Name: i2c_master_address_transmitter

Overview:
- I2C master-side counterpart to the slave address match detector.
- On request, generates a START condition and shifts out the 7-bit address plus the R/W bit.
- Samples the slave ACK/NACK on the 9th SCL pulse, then either holds the bus (ACK) or issues a STOP (NACK).
- Drives open-drain SCL/SDA pad logic at bus top level; used by the on-board bus test/bring-up controller.

Parameters:
- I2C_ADDRESS, 7'h20, target slave address, sent MSB first.
- QUARTER_CYCLES, 8, clk_i cycles (with en_i=1) per quarter SCL bit period; legal range 2..255.

Ports:
- clk_i  input  1  system clock.
- reset_i  input  1  synchronous, active-high reset.
- en_i  input  1  clock enable; all counters and the FSM freeze when 0.
- start_i  input  1  request a transfer; accepted only in IDLE.
- transfer_type_i  input  1  R/W bit, latched with start_i (0 = WRITE_OP, 1 = READ_OP).
- stop_i  input  1  request STOP; honoured only in HOLD.
- sda_i  input  1  synchronized SDA line level.
- scl_drive_low_o  output  1  1 = pull SCL low, 0 = release.
- sda_drive_low_o  output  1  1 = pull SDA low, 0 = release.
- busy_o  output  1  high in every state except IDLE.
- transfer_in_progress_o  output  1  high from START-SDA-fall through STOP-SDA-rise.
- address_ack_o  output  1  1-cycle pulse: slave ACKed.
- address_nack_o  output  1  1-cycle pulse: slave NACKed.

Behaviour:
- Reset: FSM goes to IDLE. All outputs are 0, with both lines released. Quarter counter and bit counter are cleared. Reset overrides mid-transfer with no STOP generated.
- Quarter tick: counter increments on en_i=1. Tick when count == QUARTER_CYCLES-1 and en_i=1, then wrap to 0. The FSM advances phases only on a tick.
- Registered outputs: all outputs are registered and change on the clock edge at which the tick occurs.
- IDLE: SCL and SDA are released.
  - start_i=1 latches {I2C_ADDRESS, transfer_type_i} into an 8-bit shift register and clears the quarter counter.
  - Next state START_A; busy_o=1 on the next cycle.
- START_A (1 quarter): SCL released, SDA released.
- START_B (2 quarters): SDA low with SCL released. transfer_in_progress_o=1 from entry.
- START_C (1 quarter): SCL low, SDA low.
- BIT phase: 9 bits, each 4 quarters q0..q3.
  - q0: SCL low; SDA updated at entry to the current shift-register MSB (drive low iff bit=0).
  - q1, q2: SCL released.
  - q3: SCL low.
  - SDA never changes while SCL is released.
  - Bits 1..7 carry the address, MSB first; bit 8 carries R/W.
  - Bit 9 (ACK slot): SDA released for all 4 quarters. sda_i is sampled on the q1->q2 tick; sampled 0 = ACK, 1 = NACK.
- After the 9th q3:
  - On ACK: pulse address_ack_o and go to HOLD.
  - On NACK: pulse address_nack_o and go to STOP_A.
- HOLD: SCL low, SDA released, waits indefinitely. stop_i=1 goes to STOP_A on the next clock; no tick is required, and the quarter counter is cleared.
- STOP sequence:
  - STOP_A (1 quarter): SCL low, SDA low.
  - STOP_B (1 quarter): SCL released, SDA low.
  - STOP_C (2 quarters): SCL released, SDA released. transfer_in_progress_o=0 from entry.
  - Then IDLE; busy_o=0.
- Ignored inputs:
  - start_i while busy_o=1 is ignored, never queued.
  - stop_i outside HOLD is ignored.
  - start_i and stop_i together in IDLE: start wins; stop is irrelevant there.
- No clock stretching and no arbitration: SCL readback is not used, and sda_i is only sampled in the ACK slot.
- Frame length, with en_i held 1:
  - START to end of ACK slot is 4 + 36 = 40 quarters.
  - The ACK/NACK pulse occurs 40*QUARTER_CYCLES + 1 cycles after the start_i cycle.
- en_i=0 at any point stretches the current quarter and holds the outputs stable.

Test Plan:
- I2C_ADDRESS=7'h20, QUARTER_CYCLES=2, transfer_type_i=0, sda_i held 0 in the ACK slot.
  - Response: sda_drive_low_o pattern at the 8 data bits = 1,0,1,1,1,1,1,1 (0x40 byte).
  - Exactly 9 SCL release intervals, then address_ack_o pulses once at cycle 81 after start_i.
  - HOLD is entered with scl_drive_low_o=1.
- Same setup with sda_i=1 in the ACK slot: address_nack_o pulses once, then an automatic STOP.
  - SDA rises while SCL is released; transfer_in_progress_o falls; busy_o=0 after 4 more quarters.
- transfer_type_i=1: 8th data bit released (sda_drive_low_o=0); bits 1..7 are unchanged.
- In HOLD, idle 50 cycles then pulse stop_i: outputs stable during the wait, then the STOP_A/B/C sequence. start_i pulsed mid-frame has no effect, with no second frame.
- en_i toggling 1-of-3 cycles: frame length triples, and the SCL/SDA ordering is identical to the first scenario.
- reset_i asserted during bit 5: next cycle both lines are released, all outputs are 0, FSM is in IDLE. A new start_i then runs a full correct frame.

Source files
------------

// File: rtl/i2c_master_address_transmitter.sv
// I2C master address phase: generates START, shifts out {address, R/W},
// samples the slave ACK on the 9th SCL pulse, then holds the bus (ACK)
// or issues STOP (NACK). Open-drain style outputs: 1 = pull line low.
module i2c_master_address_transmitter #(
    parameter logic [6:0]  I2C_ADDRESS    = 7'h20,
    parameter int unsigned QUARTER_CYCLES = 8
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic en_i,
    input  logic start_i,
    input  logic transfer_type_i,
    input  logic stop_i,
    input  logic sda_i,
    output logic scl_drive_low_o,
    output logic sda_drive_low_o,
    output logic busy_o,
    output logic transfer_in_progress_o,
    output logic address_ack_o,
    output logic address_nack_o
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START_A,
        S_START_B,
        S_START_C,
        S_BIT,
        S_HOLD,
        S_STOP_A,
        S_STOP_B,
        S_STOP_C
    } state_t;

    localparam logic [7:0] LAST_QUARTER = 8'(QUARTER_CYCLES - 1);
    localparam logic [3:0] ACK_SLOT     = 4'd8;

    // Quarter-period timebase
    logic [7:0] r_qcnt;
    logic       w_tick;
    logic       w_qcnt_clear;

    // FSM and datapath state
    state_t     r_state,      w_state_nxt;
    logic [1:0] r_qidx,       w_qidx_nxt;       // quarter within a bit / multi-quarter state
    logic [3:0] r_bit_cnt,    w_bit_cnt_nxt;    // 0..7 data bits, 8 = ACK slot
    logic [7:0] r_shift,      w_shift_nxt;      // MSB is the bit on the wire
    logic       r_ack_sample, w_ack_sample_nxt; // sda_i captured mid ACK slot

    // Registered outputs and their next values
    logic r_scl_low,  w_scl_low_nxt;
    logic r_sda_low,  w_sda_low_nxt;
    logic r_busy,     w_busy_nxt;
    logic r_tip,      w_tip_nxt;
    logic r_ack,      w_ack_nxt;
    logic r_nack,     w_nack_nxt;

    assign w_tick = en_i && (r_qcnt == LAST_QUARTER);

    // Quarter counter: free-runs on en_i, wraps on tick, cleared when a
    // START or STOP sequence is launched so the first quarter is full length.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset_i) begin
            r_qcnt <= 8'd0;
        end else if (w_qcnt_clear || w_tick) begin
            r_qcnt <= 8'd0;
        end else if (en_i) begin
            r_qcnt <= r_qcnt + 8'd1;
        end
    end

    // State register plus datapath registers; outputs register their decoded
    // next values so they switch on the same edge as the state.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state      <= S_IDLE;
            r_qidx       <= 2'd0;
            r_bit_cnt    <= 4'd0;
            r_shift      <= 8'd0;
            r_ack_sample <= 1'b0;
            r_scl_low    <= 1'b0;
            r_sda_low    <= 1'b0;
            r_busy       <= 1'b0;
            r_tip        <= 1'b0;
            r_ack        <= 1'b0;
            r_nack       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_qidx       <= w_qidx_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_shift      <= w_shift_nxt;
            r_ack_sample <= w_ack_sample_nxt;
            r_scl_low    <= w_scl_low_nxt;
            r_sda_low    <= w_sda_low_nxt;
            r_busy       <= w_busy_nxt;
            r_tip        <= w_tip_nxt;
            r_ack        <= w_ack_nxt;
            r_nack       <= w_nack_nxt;
        end
    end

    // Next-state logic: phases advance on quarter ticks; start/stop requests
    // act on the next enabled clock without waiting for a tick.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latch).
        w_state_nxt      = r_state;
        w_qidx_nxt       = r_qidx;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_shift_nxt      = r_shift;
        w_ack_sample_nxt = r_ack_sample;
        w_qcnt_clear     = 1'b0;
        w_ack_nxt        = 1'b0;
        w_nack_nxt       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (en_i && start_i) begin
                    w_state_nxt  = S_START_A;
                    w_shift_nxt  = {I2C_ADDRESS, transfer_type_i};
                    w_qcnt_clear = 1'b1;
                end
            end
            S_START_A: begin
                if (w_tick) begin
                    w_state_nxt = S_START_B;
                    w_qidx_nxt  = 2'd0;
                end
            end
            S_START_B: begin
                if (w_tick) begin
                    if (r_qidx == 2'd1) begin
                        w_state_nxt = S_START_C;
                    end else begin
                        w_qidx_nxt = r_qidx + 2'd1;
                    end
                end
            end
            S_START_C: begin
                if (w_tick) begin
                    w_state_nxt   = S_BIT;
                    w_qidx_nxt    = 2'd0;
                    w_bit_cnt_nxt = 4'd0;
                end
            end
            S_BIT: begin
                if (w_tick) begin
                    // Slave data is stable mid-high-phase: sample on the q1->q2 tick
                    if ((r_qidx == 2'd1) && (r_bit_cnt == ACK_SLOT)) begin
                        w_ack_sample_nxt = sda_i;
                    end
                    if (r_qidx != 2'd3) begin
                        w_qidx_nxt = r_qidx + 2'd1;
                    end else if (r_bit_cnt == ACK_SLOT) begin
                        if (!r_ack_sample) begin
                            w_ack_nxt   = 1'b1;
                            w_state_nxt = S_HOLD;
                        end else begin
                            w_nack_nxt  = 1'b1;
                            w_state_nxt = S_STOP_A;
                        end
                    end else begin
                        w_qidx_nxt    = 2'd0;
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        w_shift_nxt   = {r_shift[6:0], 1'b0};
                    end
                end
            end
            S_HOLD: begin
                if (en_i && stop_i) begin
                    w_state_nxt  = S_STOP_A;
                    w_qcnt_clear = 1'b1;
                end
            end
            S_STOP_A: begin
                if (w_tick) begin
                    w_state_nxt = S_STOP_B;
                end
            end
            S_STOP_B: begin
                if (w_tick) begin
                    w_state_nxt = S_STOP_C;
                    w_qidx_nxt  = 2'd0;
                end
            end
            S_STOP_C: begin
                if (w_tick) begin
                    if (r_qidx == 2'd1) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_qidx_nxt = r_qidx + 2'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state so the pads change on the tick edge.
    // SDA only moves while SCL is low, except for the START fall and STOP rise.
    always_comb begin
        w_scl_low_nxt = 1'b0;
        w_sda_low_nxt = 1'b0;
        w_busy_nxt    = (w_state_nxt != S_IDLE);
        w_tip_nxt     = 1'b0;

        case (w_state_nxt)
            S_START_B: begin
                w_sda_low_nxt = 1'b1;
                w_tip_nxt     = 1'b1;
            end
            S_START_C: begin
                w_scl_low_nxt = 1'b1;
                w_sda_low_nxt = 1'b1;
                w_tip_nxt     = 1'b1;
            end
            S_BIT: begin
                w_scl_low_nxt = (w_qidx_nxt == 2'd0) || (w_qidx_nxt == 2'd3);
                w_sda_low_nxt = (w_bit_cnt_nxt != ACK_SLOT) && !w_shift_nxt[7];
                w_tip_nxt     = 1'b1;
            end
            S_HOLD: begin
                w_scl_low_nxt = 1'b1;
                w_tip_nxt     = 1'b1;
            end
            S_STOP_A: begin
                w_scl_low_nxt = 1'b1;
                w_sda_low_nxt = 1'b1;
                w_tip_nxt     = 1'b1;
            end
            S_STOP_B: begin
                w_sda_low_nxt = 1'b1;
                w_tip_nxt     = 1'b1;
            end
            default: begin
                // IDLE, START_A, STOP_C: both lines released
            end
        endcase
    end

    assign scl_drive_low_o        = r_scl_low;
    assign sda_drive_low_o        = r_sda_low;
    assign busy_o                 = r_busy;
    assign transfer_in_progress_o = r_tip;
    assign address_ack_o          = r_ack;
    assign address_nack_o         = r_nack;

endmodule

// File: tb/tb_i2c_master_address_transmitter.sv
// Bench for i2c_master_address_transmitter: a quarter-level reference model
// lists the expected {SCL, SDA, busy, in-progress} per quarter and tracks
// quarter boundaries by counting enabled cycles.
module tb_i2c_master_address_transmitter;

    localparam int         Q    = 2;
    localparam logic [6:0] ADDR = 7'h20;

    logic clk_i = 1'b0;
    logic reset_i, en_i, start_i, transfer_type_i, stop_i, sda_i;
    logic scl_drive_low_o, sda_drive_low_o, busy_o, transfer_in_progress_o;
    logic address_ack_o, address_nack_o;

    i2c_master_address_transmitter #(
        .I2C_ADDRESS    (ADDR),
        .QUARTER_CYCLES (Q)
    ) dut (
        .clk_i                  (clk_i),
        .reset_i                (reset_i),
        .en_i                   (en_i),
        .start_i                (start_i),
        .transfer_type_i        (transfer_type_i),
        .stop_i                 (stop_i),
        .sda_i                  (sda_i),
        .scl_drive_low_o        (scl_drive_low_o),
        .sda_drive_low_o        (sda_drive_low_o),
        .busy_o                 (busy_o),
        .transfer_in_progress_o (transfer_in_progress_o),
        .address_ack_o          (address_ack_o),
        .address_nack_o         (address_nack_o)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    // Expected line/flag levels for one quarter
    typedef struct packed {
        logic scl;
        logic sda;
        logic busy;
        logic tip;
    } pat_t;

    pat_t exp_q[$];
    pat_t exp_tail;

    function automatic pat_t mk(input logic scl, input logic sda, input logic busy, input logic tip);
        pat_t p;
        p.scl = scl; p.sda = sda; p.busy = busy; p.tip = tip;
        return p;
    endfunction

    task automatic push_stop();
        exp_q.push_back(mk(1, 1, 1, 1));   // STOP_A
        exp_q.push_back(mk(0, 1, 1, 1));   // STOP_B
        exp_q.push_back(mk(0, 0, 1, 0));   // STOP_C
        exp_q.push_back(mk(0, 0, 1, 0));
        exp_tail = mk(0, 0, 0, 0);         // IDLE
    endtask

    task automatic build_frame(input bit rw, input bit ack_bit);
        logic [7:0] b;
        logic       d;
        b = {ADDR, rw};
        exp_q.delete();
        exp_q.push_back(mk(0, 0, 1, 0));   // START_A
        exp_q.push_back(mk(0, 1, 1, 1));   // START_B
        exp_q.push_back(mk(0, 1, 1, 1));
        exp_q.push_back(mk(1, 1, 1, 1));   // START_C
        for (int i = 0; i < 9; i++) begin
            d = (i < 8) ? !b[7 - i] : 1'b0;
            exp_q.push_back(mk(1, d, 1, 1));
            exp_q.push_back(mk(0, d, 1, 1));
            exp_q.push_back(mk(0, d, 1, 1));
            exp_q.push_back(mk(1, d, 1, 1));
        end
        if (ack_bit) exp_tail = mk(1, 0, 1, 1);   // HOLD
        else         push_stop();
    endtask

    // Launch (start or stop request), then step cycle by cycle comparing
    // the DUT against the model until stop_at quarters (0 = whole list)
    // plus 'extra' tail cycles.
    task automatic run(input bit is_stop, input bit rw, input bit ack_bit, input int p,
                       input bit noise, input int stop_at, input int extra,
                       output int ack_cycle, output logic [7:0] bits, output int releases);
        int       qi, cnt, k, stop_qi, post, guard;
        bit       advanced, done;
        logic     prev_scl, sda_ack;
        pat_t     ep;
        logic [5:0] act, expv;

        if (is_stop) begin exp_q.delete(); push_stop(); end
        else build_frame(rw, ack_bit);
        sda_ack         = !ack_bit;
        transfer_type_i = rw;
        sda_i           = sda_ack;
        en_i            = 1'b1;
        start_i         = !is_stop;
        stop_i          = is_stop;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        stop_i  = 1'b0;

        qi = 0; cnt = 0; k = 1; post = 0; guard = 0;
        ack_cycle = -1; bits = 8'h00; releases = 0;
        advanced = 1'b0; done = 1'b0; prev_scl = 1'b0;
        stop_qi = (stop_at > 0) ? stop_at : exp_q.size();

        while (!done) begin
            ep   = (qi < exp_q.size()) ? exp_q[qi] : exp_tail;
            expv = {ep, (!is_stop && advanced && qi == 40 && ack_bit),
                        (!is_stop && advanced && qi == 40 && !ack_bit)};
            act  = {scl_drive_low_o, sda_drive_low_o, busy_o, transfer_in_progress_o,
                    address_ack_o, address_nack_o};
            check($sformatf("%s cyc%0d q%0d", is_stop ? "stop" : "frame", k, qi), act, expv);
            if (address_ack_o || address_nack_o) ack_cycle = k;
            if (prev_scl && !scl_drive_low_o && qi < 40) begin
                releases++;
                if (releases <= 8) bits = {bits[6:0], sda_drive_low_o};
            end
            prev_scl = scl_drive_low_o;

            guard++;
            if (qi >= stop_qi) begin
                if (post >= extra) done = 1'b1;
                post++;
            end else if (guard > 4000) begin
                check("cycle budget", 32'(guard), 32'd4000);
                done = 1'b1;
            end

            if (!done) begin
                en_i    = (k % p == 0);
                sda_i   = (!is_stop && qi >= 36 && qi <= 39) ? sda_ack
                        : (noise ? 1'($urandom_range(0, 1)) : sda_ack);
                start_i = noise && !is_stop && qi < 40 && (qi == 20 || $urandom_range(0, 7) == 0);
                stop_i  = noise && !is_stop && qi < 40 && ($urandom_range(0, 7) == 0);
                @(posedge clk_i);
                advanced = 1'b0;
                if (en_i) begin
                    cnt++;
                    if (cnt == Q) begin
                        cnt = 0;
                        qi++;
                        advanced = 1'b1;
                    end
                end
                #1;
                start_i = 1'b0;
                stop_i  = 1'b0;
                k++;
            end
        end
        en_i = 1'b1;
    endtask

    typedef struct {
        bit         rw;
        bit         ack_bit;
        int         en_period;
        logic [7:0] exp_bits;     // sda_drive_low_o at data bits 1..8
        int         exp_ack_cycle;
        int         exp_releases;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         ac, rel;
        logic [7:0] bits;
        bit         rw, ab;
        int         p;

        vecs[0] = '{0, 1, 1, 8'b1011_1111, 81, 9};
        vecs[1] = '{0, 0, 1, 8'b1011_1111, 81, 9};
        vecs[2] = '{1, 1, 1, 8'b1011_1110, 81, 9};
        vecs[3] = '{0, 1, 3, 8'b1011_1111, 241, 9};
        vecs[4] = '{1, 0, 3, 8'b1011_1110, 241, 9};

        reset_i = 1'b1; en_i = 1'b0; start_i = 1'b0; stop_i = 1'b0;
        transfer_type_i = 1'b0; sda_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check("reset outputs", {scl_drive_low_o, sda_drive_low_o, busy_o, transfer_in_progress_o,
                                address_ack_o, address_nack_o}, 32'd0);
        reset_i = 1'b0;
        en_i    = 1'b1;
        repeat (5) @(posedge clk_i);
        #1;
        check("idle outputs", {scl_drive_low_o, sda_drive_low_o, busy_o, transfer_in_progress_o,
                               address_ack_o, address_nack_o}, 32'd0);

        // Table-driven frames
        for (int v = 0; v < 5; v++) begin
            run(0, vecs[v].rw, vecs[v].ack_bit, vecs[v].en_period, 0, 0, 4, ac, bits, rel);
            check($sformatf("vec%0d data bits", v), 32'(bits), 32'(vecs[v].exp_bits));
            check($sformatf("vec%0d ack cycle", v), 32'(ac), 32'(vecs[v].exp_ack_cycle));
            check($sformatf("vec%0d scl releases", v), 32'(rel), 32'(vecs[v].exp_releases));
            if (vecs[v].ack_bit) run(1, 0, 0, 1, 0, 0, 4, ac, bits, rel);
        end

        // Start/stop pulsed mid-frame are ignored; HOLD is stable for 50 cycles;
        // STOP then returns to IDLE with no second frame.
        run(0, 0, 1, 1, 1, 0, 50, ac, bits, rel);
        check("noisy frame ack cycle", 32'(ac), 32'd81);
        run(1, 0, 0, 1, 0, 0, 20, ac, bits, rel);

        // Reset during bit 5, then a full clean frame
        run(0, 0, 1, 1, 0, 21, 0, ac, bits, rel);
        reset_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("mid-frame reset outputs", {scl_drive_low_o, sda_drive_low_o, busy_o,
                                          transfer_in_progress_o, address_ack_o, address_nack_o}, 32'd0);
        reset_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("after reset idle", {scl_drive_low_o, sda_drive_low_o, busy_o, transfer_in_progress_o}, 32'd0);
        run(0, 1, 1, 1, 0, 0, 4, ac, bits, rel);
        check("post-reset data bits", 32'(bits), 32'b1011_1110);
        check("post-reset ack cycle", 32'(ac), 32'd81);
        run(1, 0, 0, 1, 0, 0, 4, ac, bits, rel);

        // Randomized frames against the model
        for (int r = 0; r < 8; r++) begin
            rw = 1'($urandom_range(0, 1));
            ab = 1'($urandom_range(0, 1));
            p  = $urandom_range(1, 3);
            run(0, rw, ab, p, 1, 0, 6, ac, bits, rel);
            check($sformatf("rand%0d data bits", r), 32'(bits), 32'({8'b1011_1111} & ~{7'd0, rw}));
            check($sformatf("rand%0d ack cycle", r), 32'(ac), 32'(80 * p + 1));
            if (ab) run(1, 0, 0, p, 0, 0, 6, ac, bits, rel);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
